// File: rtl/periferico_rx.sv
// rtl/periferico_rx.sv - four-phase handshake receiver feeding a show-ahead FIFO
module periferico_rx #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     send,
    input  logic [WIDTH-1:0]         dados,
    output logic                     ack,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dadosPeriferico,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_underflow,
    output logic [1:0]               estadoPeriferico
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WAIT_FULL = 2'b01,
        ST_ACK       = 2'b10,
        ST_BAD       = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s2_q;
    logic             ack_q, ack_d;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q;
    logic             wr_en, pop;
    logic             full_w, empty_w;
    logic [WIDTH-1:0] mem [DEPTH];

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);
    assign pop     = rd_en && !empty_w;
    assign count_d = count_q + CW'(wr_en) - CW'(pop);

    // A full FIFO still accepts a write when the consumer pops on the same edge.
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ack_d = 1'b0;
                if (s2_q) begin
                    if (!full_w || rd_en) begin
                        wr_en   = 1'b1;
                        ack_d   = 1'b1;
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_WAIT_FULL;
                    end
                end
            end
            ST_WAIT_FULL: begin
                ack_d = 1'b0;
                if (!full_w || rd_en) begin
                    wr_en   = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                ack_d = s2_q;
                if (!s2_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            s1_q    <= send;
            s2_q    <= s1_q;
            state_q <= state_d;
            ack_q   <= ack_d;
            count_q <= count_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (rd_en && empty_w) begin
                err_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= dados;
        end
    end

    assign ack              = ack_q;
    assign empty            = empty_w;
    assign full             = full_w;
    assign count            = count_q;
    assign err_underflow    = err_q;
    assign estadoPeriferico = state_q;
    assign dadosPeriferico  = empty_w ? '0 : mem[rd_ptr_q];

endmodule

// File: tb/tb_periferico_rx.sv
// tb/tb_periferico_rx.sv - self-checking bench for periferico_rx
`timescale 1ns/1ps
module tb_periferico_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send = 1'b0;
    logic [3:0] dados = 4'h0;
    logic       ack;
    logic       rd_en = 1'b0;
    logic [3:0] dadosPeriferico;
    logic       empty, full;
    logic [2:0] count;
    logic       err_underflow;
    logic [1:0] estadoPeriferico;

    periferico_rx #(.WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .send(send), .dados(dados), .ack(ack),
        .rd_en(rd_en), .dadosPeriferico(dadosPeriferico), .empty(empty),
        .full(full), .count(count), .err_underflow(err_underflow),
        .estadoPeriferico(estadoPeriferico)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: FIFO contents as a queue; a write is the ack rising edge.
    logic [3:0] mq[$];
    logic       mon_en = 1'b0;
    logic       ack_last = 1'b0;
    int         wr_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (rd_en && mq.size() > 0) void'(mq.pop_front());
            if (ack && !ack_last) begin
                mq.push_back(dados);
                wr_cnt++;
            end
            chk("mon_count", 32'(count), 32'(mq.size()));
            chk("mon_head", 32'(dadosPeriferico), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
            chk("mon_empty", 32'(empty), 32'(mq.size() == 0));
            chk("mon_full", 32'(full), 32'(mq.size() == 4));
            chk("mon_ack_in_idle", 32'(ack && estadoPeriferico == 2'b00), 32'd0);
        end
        ack_last = ack;
    end

    typedef struct {
        logic s; logic [3:0] d; logic r;
        logic a; logic [1:0] st; int cnt; logic [3:0] dat; logic err;
    } vec_t;
    vec_t vt[$];

    function automatic void add(logic s, logic [3:0] d, logic r, logic a,
                                logic [1:0] st, int cnt, logic [3:0] dat, logic err);
        vec_t v;
        v.s = s; v.d = d; v.r = r; v.a = a; v.st = st; v.cnt = cnt; v.dat = dat; v.err = err;
        vt.push_back(v);
    endfunction

    // One complete handshake into a non-full FIFO holding cb entries.
    function automatic void xfer(logic [3:0] d, int cb, logic [3:0] head);
        logic [3:0] hb, ha;
        hb = (cb == 0) ? 4'h0 : head;
        ha = (cb == 0) ? d : head;
        add(1, d, 0, 0, 2'b00, cb, hb, 0);
        add(1, d, 0, 0, 2'b00, cb, hb, 0);
        add(1, d, 0, 1, 2'b10, cb + 1, ha, 0);
        add(0, d, 0, 1, 2'b10, cb + 1, ha, 0);
        add(0, d, 0, 1, 2'b10, cb + 1, ha, 0);
        add(0, d, 0, 0, 2'b00, cb + 1, ha, 0);
    endfunction

    task automatic send_nibble(input logic [3:0] d);
        int t;
        @(negedge clk);
        dados = d;
        send  = 1'b1;
        t = 0;
        while (!ack && t < 40) begin @(negedge clk); t++; end
        if (!ack) chk("send_ack_timeout", 32'(ack), 32'd1);
        send = 1'b0;
        t = 0;
        while (ack && t < 40) begin @(negedge clk); t++; end
        if (ack) chk("send_release_timeout", 32'(ack), 32'd0);
    endtask

    task automatic pop_one();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic done;
    int t;

    initial begin
        // Single transfer, fill, stall on full, drain and underflow.
        xfer(4'hA, 0, 4'hA);
        add(0, 4'hA, 1, 0, 2'b00, 0, 4'h0, 0);
        xfer(4'h1, 0, 4'h1);
        xfer(4'h2, 1, 4'h1);
        xfer(4'h3, 2, 4'h1);
        xfer(4'h4, 3, 4'h1);
        add(1, 4'h5, 0, 0, 2'b00, 4, 4'h1, 0);
        add(1, 4'h5, 0, 0, 2'b00, 4, 4'h1, 0);
        add(1, 4'h5, 0, 0, 2'b01, 4, 4'h1, 0);
        add(1, 4'h5, 0, 0, 2'b01, 4, 4'h1, 0);
        add(1, 4'h5, 1, 1, 2'b10, 4, 4'h2, 0);
        add(0, 4'h5, 0, 1, 2'b10, 4, 4'h2, 0);
        add(0, 4'h5, 0, 1, 2'b10, 4, 4'h2, 0);
        add(0, 4'h5, 0, 0, 2'b00, 4, 4'h2, 0);
        add(0, 4'h5, 1, 0, 2'b00, 3, 4'h3, 0);
        add(0, 4'h5, 1, 0, 2'b00, 2, 4'h4, 0);
        add(0, 4'h5, 1, 0, 2'b00, 1, 4'h5, 0);
        add(0, 4'h5, 1, 0, 2'b00, 0, 4'h0, 0);
        add(0, 4'h5, 1, 0, 2'b00, 0, 4'h0, 1);
        add(0, 4'h5, 0, 0, 2'b00, 0, 4'h0, 1);

        #2;
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_state", 32'(estadoPeriferico), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vt[i]) begin
            send  = vt[i].s;
            dados = vt[i].d;
            rd_en = vt[i].r;
            @(negedge clk);
            chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(vt[i].a));
            chk($sformatf("vec%0d_state", i), 32'(estadoPeriferico), 32'(vt[i].st));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].cnt));
            chk($sformatf("vec%0d_data", i), 32'(dadosPeriferico), 32'(vt[i].dat));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vt[i].cnt == 0));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(vt[i].cnt == 4));
            chk($sformatf("vec%0d_err", i), 32'(err_underflow), 32'(vt[i].err));
        end
        send  = 1'b0;
        rd_en = 1'b0;

        // Asynchronous reset mid-handshake with count=3, ack=1.
        send_nibble(4'h6);
        send_nibble(4'h7);
        @(negedge clk);
        dados = 4'h8;
        send  = 1'b1;
        t = 0;
        while (!ack && t < 20) begin @(negedge clk); t++; end
        chk("prerst_ack", 32'(ack), 32'd1);
        chk("prerst_count", 32'(count), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_err", 32'(err_underflow), 32'd0);
        chk("rst_data", 32'(dadosPeriferico), 32'd0);
        chk("rst_state", 32'(estadoPeriferico), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_e1_ack", 32'(ack), 32'd0);
        @(posedge clk); #1;
        chk("rel_e2_ack", 32'(ack), 32'd0);
        @(posedge clk); #1;
        chk("rel_e3_ack", 32'(ack), 32'd1);
        chk("rel_e3_count", 32'(count), 32'd1);
        chk("rel_e3_data", 32'(dadosPeriferico), 32'h8);
        @(negedge clk);
        send = 1'b0;
        t = 0;
        while (ack && t < 20) begin @(negedge clk); t++; end
        chk("rel_ack_drop", 32'(ack), 32'd0);

        // Wrap-around with random data, occupancy kept at two or less.
        do_reset();
        mq.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_nibble(4'($urandom));
            while (mq.size() >= 2) pop_one();
            if ($urandom_range(0, 1) == 1) pop_one();
        end
        while (mq.size() > 0) pop_one();

        // Initiator on an unrelated 16 ns timebase, consumer popping at random.
        wr_cnt = 0;
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 8; n++) begin
                    dados = 4'(n);
                    send  = 1'b1;
                    for (int k = 0; k < 60 && !ack; k++) #16;
                    if (!ack) chk("async_ack_timeout", 32'(ack), 32'd1);
                    send = 1'b0;
                    for (int k = 0; k < 60 && ack; k++) #16;
                    if (ack) chk("async_release_timeout", 32'(ack), 32'd0);
                    #16;
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    rd_en = ($urandom_range(0, 3) == 0);
                end
                rd_en = 1'b0;
            end
        join
        for (int k = 0; k < 20 && mq.size() > 0; k++) pop_one();
        @(negedge clk);
        chk("async_writes", 32'(wr_cnt), 32'd8);
        chk("async_drained", 32'(empty), 32'd1);
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/periferico_rx.md
PERIFERICO_RX -- requirements
Module: periferico_rx

Interface
REQ-001 Parameter: WIDTH, 4, data nibble width in bits.
REQ-002 Parameter: DEPTH, 4, FIFO entries (power of two, >=2).
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: send  input  1  request from initiator, four-phase handshake, asynchronous to clk.
REQ-006 Port: dados  input  WIDTH  data from initiator, stable while send=1 and until ack=1.
REQ-007 Port: ack  output  1  acknowledge to initiator, registered.
REQ-008 Port: rd_en  input  1  local consumer pop request.
REQ-009 Port: dadosPeriferico  output  WIDTH  FIFO head (show-ahead), valid when empty=0.
REQ-010 Port: empty  output  1  FIFO holds zero entries.
REQ-011 Port: full  output  1  FIFO holds DEPTH entries.
REQ-012 Port: count  output  clog2(DEPTH)+1  current occupancy.
REQ-013 Port: err_underflow  output  1  sticky flag, pop attempted while empty.
REQ-014 Port: estadoPeriferico  output  2  current FSM state encoding.

Function
REQ-015 send SHALL pass through a two-flop synchronizer (s1, s2); FSM uses only s2.
REQ-016 FSM states SHALL be IDLE=2'b00, WAIT_FULL=2'b01, ACK=2'b10; 2'b11 SHALL return to IDLE next edge with ack=0 and no write.
REQ-017 IDLE, s2=1, full=0 (or full=1 with rd_en=1 same cycle): write dados to FIFO, set ack=1, go ACK.
REQ-018 IDLE, s2=1, full=1, rd_en=0: no write, ack stays 0, go WAIT_FULL.
REQ-019 WAIT_FULL: on first edge with full=0 or rd_en=1, write dados, set ack=1, go ACK; otherwise hold.
REQ-020 ACK: hold ack=1 while s2=1; on edge with s2=0, clear ack, go IDLE.
REQ-021 Exactly one FIFO write SHALL occur per send high phase.
REQ-022 Latency: send rising before edge N -> write and ack=1 visible after edge N+2 (FIFO not full); send falling before edge M -> ack=0 after edge M+2.
REQ-023 rd_en=1 with empty=0 SHALL advance read pointer by one at the edge; dadosPeriferico SHALL show the next entry after that edge.
REQ-024 rd_en=1 with empty=1 SHALL not change pointers or count and SHALL set err_underflow=1 until reset.
REQ-025 Simultaneous write and pop SHALL leave count unchanged; valid when full (pop frees slot) and when empty is false.
REQ-026 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor go below 0.
REQ-027 empty/full SHALL be derived from count and update in the same edge as the write/pop.
REQ-028 dadosPeriferico when empty=1 SHALL be 0.
REQ-029 estadoPeriferico SHALL equal the registered FSM state.

Reset
REQ-030 rst=1 SHALL immediately force: ack=0, state IDLE, s1=s2=0, pointers=0, count=0, empty=1, full=0, err_underflow=0, dadosPeriferico=0.
REQ-031 Reset mid-handshake SHALL discard FIFO contents; if send remains 1 after rst deasserts, the nibble SHALL be re-accepted as a new transaction (after 3 edges).
REQ-032 No output SHALL change on the rst-release edge other than through normal synchronizer sampling.

Verification
REQ-033 Reset: assert rst mid-run with count=3, ack=1 -> all outputs at REQ-030 values without a clock edge.
REQ-034 Single transfer: dados=4'hA, send 0->1 -> ack=1 and count=1, dadosPeriferico=4'hA after 3rd edge; drop send -> ack=0 after 3 edges; state trace 00->10->00.
REQ-035 Fill and stall: four transfers 1,2,3,4 with rd_en=0 -> full=1, count=4; fifth send (4'h5) -> state 01, ack=0; pulse rd_en one cycle -> pops 1, writes 5 same edge, count=4, ack=1.
REQ-036 Drain order: from full {1,2,3,4}, rd_en=1 four cycles -> dadosPeriferico 1,2,3,4 then empty=1, data 0; fifth rd_en -> err_underflow=1, count=0.
REQ-037 Wrap-around: 10 transfers interleaved with pops keeping count<=2 -> data out in exact send order, pointers wrap, no loss or duplicate.
REQ-038 Handshake vs initiator running on unrelated clock (e.g. 16 ns vs 10 ns period): 8 nibbles 0..7 -> exactly 8 writes, one per send pulse, ack never high while in IDLE.
